// File: rtl/vector_writeback.sv
// Destination-side write sequencer for vector functional units: waits the unit latency,
// then streams one result per clock into elements 0..VL-1 and publishes a chain count.
module vector_writeback #(
  parameter int unsigned DATA_W = 64,
  parameter int unsigned VL_W   = 7,
  parameter int unsigned LAT_W  = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              i_start,
  input  logic [VL_W-1:0]   i_vl,
  input  logic [2:0]        i_i,
  input  logic [LAT_W-1:0]  i_latency,
  input  logic [DATA_W-1:0] i_result,
  output logic              o_wr_en,
  output logic [2:0]        o_wr_sel,
  output logic [5:0]        o_wr_addr,
  output logic [DATA_W-1:0] o_wr_data,
  output logic [VL_W-1:0]   o_count,
  output logic              o_busy,
  output logic              o_done,
  output logic              o_overrun
);

  localparam int unsigned ELEM_W = 7;
  localparam logic [ELEM_W-1:0] VL_MAX = ELEM_W'(64);

  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_WRITE} state_t;

  state_t              r_state, w_state_nxt;
  logic [LAT_W-1:0]    r_cnt, w_cnt_nxt;
  logic [ELEM_W-1:0]   r_elem, w_elem_nxt;
  logic [ELEM_W-1:0]   r_vl, w_vl_nxt;
  logic                w_wr_en_nxt;
  logic [2:0]          w_sel_nxt;
  logic [5:0]          w_addr_nxt;
  logic [DATA_W-1:0]   w_data_nxt;
  logic [VL_W-1:0]     w_count_nxt;
  logic                w_busy_nxt;
  logic                w_done_nxt;
  logic                w_overrun_nxt;
  logic [ELEM_W-1:0]   w_vl_clamp;
  logic [LAT_W-1:0]    w_lat;

  // Issue-time operand conditioning: vl saturates at 64, latency 0 acts as 1
  always_comb begin
    w_vl_clamp = (i_vl > VL_W'(VL_MAX)) ? VL_MAX : ELEM_W'(i_vl);
    w_lat      = (i_latency == '0) ? LAT_W'(1) : i_latency;
  end

  always_comb begin
    w_state_nxt   = r_state;
    w_cnt_nxt     = r_cnt;
    w_elem_nxt    = r_elem;
    w_vl_nxt      = r_vl;
    w_wr_en_nxt   = 1'b0;
    w_sel_nxt     = o_wr_sel;
    w_addr_nxt    = o_wr_addr;
    w_data_nxt    = o_wr_data;
    w_count_nxt   = o_count;
    w_done_nxt    = 1'b0;
    w_overrun_nxt = o_overrun;

    case (r_state)
      S_IDLE: begin
        // A write still showing on the outputs means the previous op just finished
        w_done_nxt = o_wr_en;
        if (i_start) begin
          w_sel_nxt   = i_i;
          w_count_nxt = '0;
          w_elem_nxt  = '0;
          w_vl_nxt    = w_vl_clamp;
          if (w_vl_clamp == '0) begin
            w_done_nxt = 1'b1;
          end else if (w_lat == LAT_W'(1)) begin
            w_state_nxt = S_WRITE;
          end else begin
            w_state_nxt = S_WAIT;
            w_cnt_nxt   = w_lat - LAT_W'(1);
          end
        end
      end
      S_WAIT: begin
        if (i_start) w_overrun_nxt = 1'b1;
        w_cnt_nxt = r_cnt - LAT_W'(1);
        if (r_cnt == LAT_W'(1)) w_state_nxt = S_WRITE;
      end
      S_WRITE: begin
        if (i_start) w_overrun_nxt = 1'b1;
        w_wr_en_nxt = 1'b1;
        w_data_nxt  = i_result;
        w_addr_nxt  = r_elem[5:0];
        w_elem_nxt  = r_elem + ELEM_W'(1);
        w_count_nxt = o_count + VL_W'(1);
        if (r_elem == r_vl - ELEM_W'(1)) w_state_nxt = S_IDLE;
      end
      default: w_state_nxt = S_IDLE;
    endcase

    w_busy_nxt = (w_state_nxt != S_IDLE) | w_wr_en_nxt;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state   <= S_IDLE;
      r_cnt     <= '0;
      r_elem    <= '0;
      r_vl      <= '0;
      o_wr_en   <= 1'b0;
      o_wr_sel  <= '0;
      o_wr_addr <= '0;
      o_wr_data <= '0;
      o_count   <= '0;
      o_busy    <= 1'b0;
      o_done    <= 1'b0;
      o_overrun <= 1'b0;
    end else begin
      r_state   <= w_state_nxt;
      r_cnt     <= w_cnt_nxt;
      r_elem    <= w_elem_nxt;
      r_vl      <= w_vl_nxt;
      o_wr_en   <= w_wr_en_nxt;
      o_wr_sel  <= w_sel_nxt;
      o_wr_addr <= w_addr_nxt;
      o_wr_data <= w_data_nxt;
      o_count   <= w_count_nxt;
      o_busy    <= w_busy_nxt;
      o_done    <= w_done_nxt;
      o_overrun <= w_overrun_nxt;
    end
  end

endmodule

// File: tb/tb_vector_writeback.sv
// Directed bench for vector_writeback: a per-edge vector table for one operation,
// plus hand sequences for length/latency corners, overrun, mid-op reset and chaining.
module tb_vector_writeback;

  logic        clk = 1'b0;
  logic        rst;
  logic        i_start;
  logic [6:0]  i_vl;
  logic [2:0]  i_i;
  logic [3:0]  i_latency;
  logic [63:0] i_result;
  logic        o_wr_en;
  logic [2:0]  o_wr_sel;
  logic [5:0]  o_wr_addr;
  logic [63:0] o_wr_data;
  logic [6:0]  o_count;
  logic        o_busy;
  logic        o_done;
  logic        o_overrun;

  vector_writeback #(.DATA_W(64), .VL_W(7), .LAT_W(4)) dut (
    .clk(clk), .rst(rst), .i_start(i_start), .i_vl(i_vl), .i_i(i_i),
    .i_latency(i_latency), .i_result(i_result), .o_wr_en(o_wr_en),
    .o_wr_sel(o_wr_sel), .o_wr_addr(o_wr_addr), .o_wr_data(o_wr_data),
    .o_count(o_count), .o_busy(o_busy), .o_done(o_done), .o_overrun(o_overrun)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        start;
    logic        wr;
    logic [5:0]  addr;
    logic [63:0] data;
    logic [6:0]  count;
    logic        busy;
    logic        done;
  } vec_t;

  vec_t tbl [11];

  int checks = 0;
  int errors = 0;
  int ecnt   = 0;
  logic [6:0] pvl;
  logic [2:0] pi;
  logic [3:0] plat;

  function automatic string act();
    return $sformatf("wr_en=%0b sel=%0d addr=%0d data=%h count=%0d busy=%0b done=%0b ovr=%0b",
                     o_wr_en, o_wr_sel, o_wr_addr, o_wr_data, o_count, o_busy, o_done, o_overrun);
  endfunction

  task automatic check(input string name, input bit ok, input string need);
    checks++;
    if (!ok) begin
      errors++;
      $display("FAIL %s: got %s | need %s", name, act(), need);
    end
  endtask

  // Result presented at edge k (counted from the issue edge) is 0x100+k
  task automatic step();
    i_result = 64'h100 + 64'(ecnt);
    @(posedge clk);
    #1;
    ecnt++;
  endtask

  task automatic issue(input logic [6:0] vl, input logic [2:0] sel, input logic [3:0] lat);
    ecnt      = 0;
    i_start   = 1'b1;
    i_vl      = vl;
    i_i       = sel;
    i_latency = lat;
    step();
    i_start = 1'b0;
  endtask

  // Walks edges E1.. of an op issued at E0; optional extra i_start at poke_k (overrun or chained issue)
  task automatic run_check(input string name, input int n, input int l, input logic [2:0] sel,
                           input int poke_k, input bit chain);
    int  last;
    bit  writing, chained, ok;
    int  ecount;
    bit  ebusy, edone;
    last = chain ? l + n : l + n + 1;
    for (int k = 1; k <= last; k++) begin
      if (k == poke_k) begin
        i_start = 1'b1; i_vl = pvl; i_i = pi; i_latency = plat;
      end
      step();
      i_start = 1'b0;
      writing = (k >= l) && (k <= l + n - 1);
      chained = chain && (k == poke_k);
      ebusy   = chained ? 1'b1 : (k < l + n);
      edone   = (k == l + n);
      ecount  = chained ? 0 : (writing ? k - l + 1 : (k < l ? 0 : n));
      ok = (o_wr_en == writing) && (o_busy == ebusy) && (o_done == edone) &&
           (o_count == 7'(ecount));
      if (writing)
        ok = ok && (o_wr_addr == 6'(k - l)) && (o_wr_data == 64'h100 + 64'(k)) && (o_wr_sel == sel);
      check($sformatf("%s_E%0d", name, k), ok,
            $sformatf("wr_en=%0b sel=%0d addr=%0d data=%h count=%0d busy=%0b done=%0b",
                      writing, sel, k - l, 64'h100 + 64'(k), ecount, ebusy, edone));
    end
  endtask

  initial begin
    // Single op vl=5 sel=3 lat=4: writes after E4..E8, done after E9
    tbl[0]  = '{1'b1, 1'b0, 6'd0, 64'h0,   7'd0, 1'b1, 1'b0};
    tbl[1]  = '{1'b0, 1'b0, 6'd0, 64'h0,   7'd0, 1'b1, 1'b0};
    tbl[2]  = '{1'b0, 1'b0, 6'd0, 64'h0,   7'd0, 1'b1, 1'b0};
    tbl[3]  = '{1'b0, 1'b0, 6'd0, 64'h0,   7'd0, 1'b1, 1'b0};
    tbl[4]  = '{1'b0, 1'b1, 6'd0, 64'h104, 7'd1, 1'b1, 1'b0};
    tbl[5]  = '{1'b0, 1'b1, 6'd1, 64'h105, 7'd2, 1'b1, 1'b0};
    tbl[6]  = '{1'b0, 1'b1, 6'd2, 64'h106, 7'd3, 1'b1, 1'b0};
    tbl[7]  = '{1'b0, 1'b1, 6'd3, 64'h107, 7'd4, 1'b1, 1'b0};
    tbl[8]  = '{1'b0, 1'b1, 6'd4, 64'h108, 7'd5, 1'b1, 1'b0};
    tbl[9]  = '{1'b0, 1'b0, 6'd0, 64'h0,   7'd5, 1'b0, 1'b1};
    tbl[10] = '{1'b0, 1'b0, 6'd0, 64'h0,   7'd5, 1'b0, 1'b0};

    rst = 1'b1; i_start = 1'b0; i_vl = 7'd0; i_i = 3'd0; i_latency = 4'd0; i_result = 64'h0;
    step(); step();
    check("reset_state",
          {o_wr_en, o_wr_sel, o_wr_addr, o_wr_data, o_count, o_busy, o_done, o_overrun} == '0,
          "all outputs 0");
    rst = 1'b0;
    step();

    ecnt = 0;
    for (int r = 0; r < 11; r++) begin
      i_start = tbl[r].start; i_vl = 7'd5; i_i = 3'd3; i_latency = 4'd4;
      step();
      i_start = 1'b0;
      check($sformatf("table_E%0d", r),
            (o_wr_en == tbl[r].wr) && (o_count == tbl[r].count) && (o_busy == tbl[r].busy) &&
            (o_done == tbl[r].done) && (o_wr_sel == 3'd3) && (o_overrun == 1'b0) &&
            (!tbl[r].wr || ((o_wr_addr == tbl[r].addr) && (o_wr_data == tbl[r].data))),
            $sformatf("wr_en=%0b sel=3 addr=%0d data=%h count=%0d busy=%0b done=%0b ovr=0",
                      tbl[r].wr, tbl[r].addr, tbl[r].data, tbl[r].count, tbl[r].busy, tbl[r].done));
    end

    issue(7'd64, 3'd1, 4'd1);
    run_check("full64", 64, 1, 3'd1, 0, 1'b0);

    issue(7'd100, 3'd2, 4'd1);
    run_check("vl100", 64, 1, 3'd2, 0, 1'b0);

    issue(7'd4, 3'd5, 4'd0);
    run_check("lat0", 4, 1, 3'd5, 0, 1'b0);

    issue(7'd0, 3'd2, 4'd3);
    check("vl0_done", (o_done == 1'b1) && (o_wr_en == 1'b0) && (o_busy == 1'b0) && (o_count == 7'd0),
          "done=1 wr_en=0 busy=0 count=0");
    step();
    check("vl0_after", (o_done == 1'b0) && (o_wr_en == 1'b0) && (o_busy == 1'b0),
          "done=0 wr_en=0 busy=0");

    pvl = 7'd5; pi = 3'd6; plat = 4'd4;
    issue(7'd5, 3'd2, 4'd4);
    run_check("overrun_op", 5, 4, 3'd2, 3, 1'b0);
    check("overrun_set", o_overrun == 1'b1, "ovr=1");
    issue(7'd3, 3'd1, 4'd2);
    run_check("post_overrun", 3, 2, 3'd1, 0, 1'b0);
    check("overrun_sticky", o_overrun == 1'b1, "ovr=1");

    issue(7'd10, 3'd5, 4'd4);
    for (int k = 1; k <= 5; k++) step();
    check("pre_rst_write", (o_wr_en == 1'b1) && (o_wr_addr == 6'd1) && (o_count == 7'd2),
          "wr_en=1 addr=1 count=2");
    rst = 1'b1;
    step();
    check("mid_rst_zero",
          {o_wr_en, o_wr_sel, o_wr_addr, o_wr_data, o_count, o_busy, o_done, o_overrun} == '0,
          "all outputs 0");
    rst = 1'b0;
    for (int k = 0; k < 12; k++) begin
      step();
      check($sformatf("post_rst_quiet_%0d", k),
            (o_wr_en == 1'b0) && (o_done == 1'b0) && (o_busy == 1'b0), "wr_en=0 done=0 busy=0");
    end
    issue(7'd2, 3'd4, 4'd1);
    run_check("after_rst", 2, 1, 3'd4, 0, 1'b0);

    pvl = 7'd2; pi = 3'd7; plat = 4'd1;
    issue(7'd3, 3'd1, 4'd2);
    run_check("chain_a", 3, 2, 3'd1, 5, 1'b1);
    ecnt = 1;
    run_check("chain_b", 2, 1, 3'd7, 0, 1'b0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
